// File: rtl/axil_master_pkg.sv
// Shared constants and FSM state encodings for the AXI4-Lite master engine.
package axil_master_pkg;

    localparam logic [1:0] RespOkay   = 2'd0;
    localparam logic [1:0] RespExokay = 2'd1;
    localparam logic [1:0] RespSlverr = 2'd2;
    localparam logic [1:0] RespDecerr = 2'd3;

    localparam logic [2:0] AxiProt = 3'b000;

    typedef enum logic [1:0] {
        WIdle = 2'd0,
        WAddr = 2'd1,
        WResp = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        RIdle = 2'd0,
        RAddr = 2'd1,
        RData = 2'd2
    } rd_state_e;

endpackage

// File: rtl/axil_master_watchdog.sv
// Per-path watchdog: counts busy cycles and raises a sticky flag at TIMEOUT.
module axil_master_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic busy_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] count_q, count_d;
    logic            flag_q, flag_d;

    always_comb begin
        count_d = count_q;
        flag_d  = flag_q;
        if (clear_i) begin
            count_d = '0;
            flag_d  = 1'b0;
        end else if (busy_i && count_q != CntW'(TIMEOUT)) begin
            count_d = count_q + 1'b1;
            // Flag rises in the same cycle the count shows TIMEOUT.
            if (count_q == CntW'(TIMEOUT - 1)) begin
                flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign timeout_o = flag_q;

endmodule

// File: rtl/axil_master.sv
// AXI4-Lite master: independent single-beat write and read engines.
// Optional watchdog flags enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_master
    import axil_master_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_start,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_strb,
    output logic          wr_idle,
    output logic          wr_done,
    output logic [1:0]    wr_resp,
    input  logic          rd_start,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_idle,
    output logic          rd_done,
    output logic [31:0]   rd_data,
    output logic [1:0]    rd_resp,
    output logic          wr_timeout,
    output logic          rd_timeout,
    output logic [AW-1:0] M_AXI_AWADDR,
    output logic [2:0]    M_AXI_AWPROT,
    output logic          M_AXI_AWVALID,
    input  logic          M_AXI_AWREADY,
    output logic [31:0]   M_AXI_WDATA,
    output logic [3:0]    M_AXI_WSTRB,
    output logic          M_AXI_WVALID,
    input  logic          M_AXI_WREADY,
    input  logic [1:0]    M_AXI_BRESP,
    input  logic          M_AXI_BVALID,
    output logic          M_AXI_BREADY,
    output logic [AW-1:0] M_AXI_ARADDR,
    output logic [2:0]    M_AXI_ARPROT,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    input  logic [31:0]   M_AXI_RDATA,
    input  logic [1:0]    M_AXI_RRESP,
    input  logic          M_AXI_RVALID,
    output logic          M_AXI_RREADY
);

    wr_state_e     wr_state_q, wr_state_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          b_got_q, b_got_d;
    logic [1:0]    b_resp_q, b_resp_d;
    logic          wr_done_q, wr_done_d;
    logic [1:0]    wr_resp_q, wr_resp_d;

    rd_state_e     rd_state_q, rd_state_d;
    logic [AW-1:0] araddr_q, araddr_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          rd_done_q, rd_done_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic [1:0]    rd_resp_q, rd_resp_d;

    logic wr_accept, rd_accept;

    assign wr_accept = wr_start && (wr_state_q == WIdle);
    assign rd_accept = rd_start && (rd_state_q == RIdle);

    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        b_got_d    = b_got_q;
        b_resp_d   = b_resp_q;
        wr_resp_d  = wr_resp_q;
        wr_done_d  = 1'b0;
        unique case (wr_state_q)
            WIdle: begin
                if (wr_start) begin
                    awaddr_d   = wr_addr;
                    wdata_d    = wr_data;
                    wstrb_d    = wr_strb;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    wr_state_d = WAddr;
                end
            end
            WAddr: begin
                // AW and W retire independently; move on once both are gone.
                awvalid_d = awvalid_q && !M_AXI_AWREADY;
                wvalid_d  = wvalid_q && !M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d   = 1'b1;
                    wr_state_d = WResp;
                end
            end
            WResp: begin
                if (b_got_q) begin
                    b_got_d    = 1'b0;
                    wr_resp_d  = b_resp_q;
                    wr_done_d  = 1'b1;
                    wr_state_d = WIdle;
                end else if (bready_q && M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    b_got_d  = 1'b1;
                    b_resp_d = M_AXI_BRESP;
                end
            end
            default: wr_state_d = WIdle;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        araddr_d   = araddr_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        rd_data_d  = rd_data_q;
        rd_resp_d  = rd_resp_q;
        rd_done_d  = 1'b0;
        unique case (rd_state_q)
            RIdle: begin
                if (rd_start) begin
                    araddr_d   = rd_addr;
                    arvalid_d  = 1'b1;
                    rd_state_d = RAddr;
                end
            end
            RAddr: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b1;
                    rd_state_d = RData;
                end
            end
            RData: begin
                if (rready_q && M_AXI_RVALID) begin
                    rready_d   = 1'b0;
                    rd_data_d  = M_AXI_RDATA;
                    rd_resp_d  = M_AXI_RRESP;
                    rd_done_d  = 1'b1;
                    rd_state_d = RIdle;
                end
            end
            default: rd_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state_q <= WIdle;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            b_got_q    <= 1'b0;
            b_resp_q   <= RespOkay;
            wr_done_q  <= 1'b0;
            wr_resp_q  <= RespOkay;
            rd_state_q <= RIdle;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_resp_q  <= RespOkay;
        end else begin
            wr_state_q <= wr_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            b_got_q    <= b_got_d;
            b_resp_q   <= b_resp_d;
            wr_done_q  <= wr_done_d;
            wr_resp_q  <= wr_resp_d;
            rd_state_q <= rd_state_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            rd_done_q  <= rd_done_d;
            rd_data_q  <= rd_data_d;
            rd_resp_q  <= rd_resp_d;
        end
    end

    assign wr_idle = (wr_state_q == WIdle) && !wr_start;
    assign rd_idle = (rd_state_q == RIdle) && !rd_start;
    assign wr_done = wr_done_q;
    assign wr_resp = wr_resp_q;
    assign rd_done = rd_done_q;
    assign rd_data = rd_data_q;
    assign rd_resp = rd_resp_q;

    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = AxiProt;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = AxiProt;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
    axil_master_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wr_watchdog (
        .clk      (clk),
        .resetn   (resetn),
        .busy_i   (wr_state_q != WIdle),
        .clear_i  (wr_accept),
        .timeout_o(wr_timeout)
    );

    axil_master_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_rd_watchdog (
        .clk      (clk),
        .resetn   (resetn),
        .busy_i   (rd_state_q != RIdle),
        .clear_i  (rd_accept),
        .timeout_o(rd_timeout)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0) ^ wr_accept ^ rd_accept;
    assign wr_timeout     = 1'b0;
    assign rd_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_axil_master.sv
// Directed self-checking bench for axil_master; the slave side is scripted per cycle.
module tb_axil_master;
    import axil_master_pkg::*;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_start = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic [3:0]    wr_strb = '0;
    logic          wr_idle, wr_done;
    logic [1:0]    wr_resp;
    logic          rd_start = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_idle, rd_done;
    logic [31:0]   rd_data;
    logic [1:0]    rd_resp;
    logic          wr_timeout, rd_timeout;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic          arready = 1'b0, rvalid = 1'b0;
    logic [1:0]    bresp = 2'd0, rresp = 2'd0;
    logic [31:0]   rdata_in = '0;

    int checks = 0;
    int errors = 0;
    int aw_hs = 0, ar_hs = 0, b_hs = 0, wr_dones = 0, rd_dones = 0;

    always #5 clk = ~clk;

    axil_master #(
        .AW     (AW),
        .TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wr_start     (wr_start),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .wr_idle      (wr_idle),
        .wr_done      (wr_done),
        .wr_resp      (wr_resp),
        .rd_start     (rd_start),
        .rd_addr      (rd_addr),
        .rd_idle      (rd_idle),
        .rd_done      (rd_done),
        .rd_data      (rd_data),
        .rd_resp      (rd_resp),
        .wr_timeout   (wr_timeout),
        .rd_timeout   (rd_timeout),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWPROT (awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARPROT (arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata_in),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

    always @(posedge clk) begin
        if (awvalid && awready) aw_hs <= aw_hs + 1;
        if (arvalid && arready) ar_hs <= ar_hs + 1;
        if (bvalid && bready) b_hs <= b_hs + 1;
        if (wr_done) wr_dones <= wr_dones + 1;
        if (rd_done) rd_dones <= rd_dones + 1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_handshake: got %b expected 00000",
                     {awvalid, wvalid, bready, arvalid, rready});
        end
        checks++;
        if ({wr_idle, rd_idle, wr_done, rd_done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_status: got %b expected 1100", {wr_idle, rd_idle, wr_done, rd_done});
        end
        checks++;
        if ({wr_resp, rd_resp, rd_data, wr_timeout, rd_timeout} !== 38'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h/%b%b expected all 0",
                     wr_resp, rd_resp, rd_data, wr_timeout, rd_timeout);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_zero_wait_write();
        wr_addr = 32'h4; wr_data = 32'hDEADBEEF; wr_strb = 4'hF; wr_start = 1'b1;
        awready = 1'b1; wready = 1'b1;
        #1;
        checks++;
        if (wr_idle !== 1'b0) begin
            errors++; $display("FAIL zw_idle_on_start: got %b expected 0", wr_idle);
        end
        tick(); wr_start = 1'b0;  // cycle 1
        checks++;
        if ({awvalid, wvalid, bready, awprot} !== 6'b110000 || awaddr !== 32'h4
            || wdata !== 32'hDEADBEEF || wstrb !== 4'hF) begin
            errors++;
            $display("FAIL zw_request: got v=%b%b%b prot=%h a=%h d=%h s=%h expected 110 0 4 deadbeef f",
                     awvalid, wvalid, bready, awprot, awaddr, wdata, wstrb);
        end
        tick();  // cycle 2
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            errors++; $display("FAIL zw_bready: got %b expected 001", {awvalid, wvalid, bready});
        end
        bvalid = 1'b1; bresp = RespOkay;
        tick(); bvalid = 1'b0;  // cycle 3
        checks++;
        if ({bready, wr_done} !== 2'b00) begin
            errors++; $display("FAIL zw_cycle3: got %b expected 00", {bready, wr_done});
        end
        tick();  // cycle 4
        checks++;
        if ({wr_done, wr_idle, wr_resp} !== 4'b1100) begin
            errors++; $display("FAIL zw_done: got %b expected 1100", {wr_done, wr_idle, wr_resp});
        end
        tick();
        checks++;
        if (wr_done !== 1'b0) begin
            errors++; $display("FAIL zw_done_pulse: got %b expected 0", wr_done);
        end
        awready = 1'b0; wready = 1'b0;
    endtask

    task automatic test_split_handshake();
        int a0, b0, d0;
        // W accepted three cycles before AW.
        a0 = aw_hs; b0 = b_hs; d0 = wr_dones;
        wr_addr = 32'h20; wr_data = 32'h0000_1111; wr_strb = 4'h3; wr_start = 1'b1;
        tick(); wr_start = 1'b0; wready = 1'b1;  // cycle 1
        tick(); wready = 1'b0;                   // cycle 2
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b100) begin
            errors++; $display("FAIL w_first_c2: got %b expected 100", {awvalid, wvalid, bready});
        end
        tick();                                  // cycle 3
        tick(); awready = 1'b1;                  // cycle 4
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 32'h20) begin
            errors++;
            $display("FAIL w_first_c4: got %b addr %h expected 100 addr 20", {awvalid, wvalid, bready}, awaddr);
        end
        tick(); awready = 1'b0;                  // cycle 5
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            errors++; $display("FAIL w_first_c5: got %b expected 001", {awvalid, wvalid, bready});
        end
        bvalid = 1'b1; bresp = RespSlverr;
        tick(); bvalid = 1'b0;                   // cycle 6
        tick();                                  // cycle 7
        checks++;
        if ({wr_done, wr_resp} !== {1'b1, RespSlverr}) begin
            errors++; $display("FAIL w_first_done: got %b expected 110", {wr_done, wr_resp});
        end
        tick();
        checks++;
        if (aw_hs - a0 != 1 || b_hs - b0 != 1 || wr_dones - d0 != 1) begin
            errors++;
            $display("FAIL w_first_counts: got aw=%0d b=%0d done=%0d expected 1 1 1",
                     aw_hs - a0, b_hs - b0, wr_dones - d0);
        end
        // AW accepted three cycles before W, one B wait cycle.
        a0 = aw_hs; b0 = b_hs; d0 = wr_dones;
        wr_addr = 32'h24; wr_data = 32'h0000_2222; wr_strb = 4'hC; wr_start = 1'b1;
        tick(); wr_start = 1'b0; awready = 1'b1; // cycle 1
        tick(); awready = 1'b0;                  // cycle 2
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b010) begin
            errors++; $display("FAIL aw_first_c2: got %b expected 010", {awvalid, wvalid, bready});
        end
        tick();                                  // cycle 3
        checks++;
        if (wvalid !== 1'b1 || wdata !== 32'h0000_2222 || wstrb !== 4'hC) begin
            errors++;
            $display("FAIL aw_first_payload: got v=%b d=%h s=%h expected 1 00002222 c", wvalid, wdata, wstrb);
        end
        tick(); wready = 1'b1;                   // cycle 4
        tick(); wready = 1'b0;                   // cycle 5
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            errors++; $display("FAIL aw_first_c5: got %b expected 001", {awvalid, wvalid, bready});
        end
        tick(); bvalid = 1'b1; bresp = RespExokay; // cycle 6
        tick(); bvalid = 1'b0;                   // cycle 7
        tick();                                  // cycle 8
        checks++;
        if ({wr_done, wr_resp} !== {1'b1, RespExokay}) begin
            errors++; $display("FAIL aw_first_done: got %b expected 101", {wr_done, wr_resp});
        end
        tick();
        checks++;
        if (aw_hs - a0 != 1 || b_hs - b0 != 1 || wr_dones - d0 != 1) begin
            errors++;
            $display("FAIL aw_first_counts: got aw=%0d b=%0d done=%0d expected 1 1 1",
                     aw_hs - a0, b_hs - b0, wr_dones - d0);
        end
    endtask

    task automatic test_read_wait();
        rd_addr = 32'h8; rd_start = 1'b1; arready = 1'b1;
        #1;
        checks++;
        if (rd_idle !== 1'b0) begin
            errors++; $display("FAIL rd_idle_on_start: got %b expected 0", rd_idle);
        end
        tick(); rd_start = 1'b0;  // cycle 1
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8 || arprot !== 3'b000) begin
            errors++;
            $display("FAIL rd_ar: got v=%b a=%h p=%h expected 1 8 0", arvalid, araddr, arprot);
        end
        tick(); arready = 1'b0;   // cycle 2
        checks++;
        if ({arvalid, rready} !== 2'b01) begin
            errors++; $display("FAIL rd_rready: got %b expected 01", {arvalid, rready});
        end
        for (int i = 0; i < 4; i++) tick();  // cycles 3..6
        checks++;
        if ({rready, rd_done} !== 2'b10) begin
            errors++; $display("FAIL rd_waiting: got %b expected 10", {rready, rd_done});
        end
        tick(); rvalid = 1'b1; rdata_in = 32'h12345678; rresp = RespDecerr;  // cycle 7
        tick(); rvalid = 1'b0;    // cycle 8
        checks++;
        if ({rd_done, rready, rd_idle} !== 3'b101 || rd_data !== 32'h12345678 || rd_resp !== 2'd3) begin
            errors++;
            $display("FAIL rd_done: got %b data %h resp %0d expected 101 data 12345678 resp 3",
                     {rd_done, rready, rd_idle}, rd_data, rd_resp);
        end
        tick();
        checks++;
        if (rd_done !== 1'b0 || rd_data !== 32'h12345678) begin
            errors++; $display("FAIL rd_hold: got %b %h expected 0 12345678", rd_done, rd_data);
        end
    endtask

    task automatic test_concurrent();
        int a0, r0, d0;
        a0 = aw_hs; r0 = ar_hs; d0 = wr_dones;
        wr_addr = 32'h10; wr_data = 32'hA5A5A5A5; wr_strb = 4'hF; wr_start = 1'b1;
        rd_addr = 32'h14; rd_start = 1'b1;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        tick(); rd_start = 1'b0; wr_addr = 32'h40;  // cycle 1, wr_start repeated while busy
        checks++;
        if ({awvalid, wvalid, arvalid} !== 3'b111 || awaddr !== 32'h10 || araddr !== 32'h14) begin
            errors++;
            $display("FAIL cc_issue: got %b aw=%h ar=%h expected 111 10 14", {awvalid, wvalid, arvalid}, awaddr, araddr);
        end
        tick(); wr_start = 1'b0;  // cycle 2
        bvalid = 1'b1; bresp = RespOkay; rvalid = 1'b1; rdata_in = 32'hCAFEF00D; rresp = RespOkay;
        checks++;
        if ({bready, rready} !== 2'b11) begin
            errors++; $display("FAIL cc_readies: got %b expected 11", {bready, rready});
        end
        tick(); bvalid = 1'b0; rvalid = 1'b0;  // cycle 3
        checks++;
        if ({rd_done, wr_done} !== 2'b10 || rd_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL cc_rd_done: got %b data %h expected 10 cafef00d", {rd_done, wr_done}, rd_data);
        end
        tick();  // cycle 4
        checks++;
        if ({wr_done, wr_resp} !== 3'b100) begin
            errors++; $display("FAIL cc_wr_done: got %b expected 100", {wr_done, wr_resp});
        end
        tick(); tick();
        checks++;
        if (aw_hs - a0 != 1 || ar_hs - r0 != 1 || wr_dones - d0 != 1 || awvalid !== 1'b0) begin
            errors++;
            $display("FAIL cc_single_aw: got aw=%0d ar=%0d done=%0d awvalid=%b expected 1 1 1 0",
                     aw_hs - a0, ar_hs - r0, wr_dones - d0, awvalid);
        end
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
    endtask

    task automatic test_async_reset();
        wr_addr = 32'h30; wr_data = 32'h1; wr_strb = 4'h1; wr_start = 1'b1;
        awready = 1'b1; wready = 1'b1;
        tick(); wr_start = 1'b0;  // cycle 1
        tick();                   // cycle 2
        checks++;
        if ({bready, wr_idle} !== 2'b10) begin
            errors++; $display("FAIL ar_in_wresp: got %b expected 10", {bready, wr_idle});
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({bready, wr_idle, awvalid} !== 3'b010) begin
            errors++; $display("FAIL ar_abort: got %b expected 010", {bready, wr_idle, awvalid});
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        wr_addr = 32'h34; wr_data = 32'h0BADF00D; wr_strb = 4'hF; wr_start = 1'b1;
        tick(); wr_start = 1'b0;  // cycle 1
        checks++;
        if ({awvalid, wvalid} !== 2'b11 || awaddr !== 32'h34 || wdata !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL ar_fresh_req: got %b a=%h d=%h expected 11 34 0badf00d", {awvalid, wvalid}, awaddr, wdata);
        end
        tick(); bvalid = 1'b1; bresp = RespSlverr;  // cycle 2
        tick(); bvalid = 1'b0;    // cycle 3
        tick();                   // cycle 4
        checks++;
        if ({wr_done, wr_resp} !== {1'b1, RespSlverr}) begin
            errors++; $display("FAIL ar_fresh_done: got %b expected 110", {wr_done, wr_resp});
        end
        awready = 1'b0; wready = 1'b0;
        tick();
    endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        wr_addr = 32'h50; wr_data = 32'h5; wr_strb = 4'hF; wr_start = 1'b1;
        awready = 1'b1; wready = 1'b1;
        tick(); wr_start = 1'b0;  // cycle 1, count 0
        for (int i = 0; i < 15; i++) tick();  // cycle 16, count 15
        checks++;
        if (wr_timeout !== 1'b0) begin
            errors++; $display("FAIL to_early: got %b expected 0", wr_timeout);
        end
        tick();                   // cycle 17, count 16
        checks++;
        if ({wr_timeout, rd_timeout} !== 2'b10) begin
            errors++; $display("FAIL to_set: got %b expected 10", {wr_timeout, rd_timeout});
        end
        for (int i = 0; i < 23; i++) tick();  // cycle 40
        checks++;
        if ({wr_timeout, bready} !== 2'b11) begin
            errors++; $display("FAIL to_waiting: got %b expected 11", {wr_timeout, bready});
        end
        bvalid = 1'b1; bresp = RespOkay;
        tick(); bvalid = 1'b0;
        tick();
        checks++;
        if ({wr_done, wr_timeout} !== 2'b11) begin
            errors++; $display("FAIL to_complete: got %b expected 11", {wr_done, wr_timeout});
        end
        wr_start = 1'b1;
        tick(); wr_start = 1'b0;
        checks++;
        if (wr_timeout !== 1'b0) begin
            errors++; $display("FAIL to_clear: got %b expected 0", wr_timeout);
        end
        tick(); bvalid = 1'b1;
        tick(); bvalid = 1'b0;
        tick(); tick();
        awready = 1'b0; wready = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_wait_write();
        test_split_handshake();
        test_read_wait();
        test_concurrent();
        test_async_reset();
`ifdef AXIL_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
